// File: rtl/npc_pkg.sv
// -----------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the NPC pipeline execute front end.
//   XLEN          : datapath width (operands, PC, immediate)
//   ALUOP_W       : ALU opcode width
//   ALU_*         : ALU opcode constants (33 opcodes)
//   ex_payload_t  : everything the ALU and later stages need for one instruction
//   occ_state_t   : occupancy of the (main, skid) entry pair, encoded {main, skid}
// -----------------------------------------------------------------------------
package npc_pkg;

    localparam int XLEN    = 64;
    localparam int ALUOP_W = 6;

    typedef logic [ALUOP_W-1:0] alu_op_t;

    localparam int ALU_OP_COUNT = 33;

    localparam alu_op_t ALU_ADD    = 6'd0;
    localparam alu_op_t ALU_SUB    = 6'd1;
    localparam alu_op_t ALU_SLL    = 6'd2;
    localparam alu_op_t ALU_SLT    = 6'd3;
    localparam alu_op_t ALU_SLTU   = 6'd4;
    localparam alu_op_t ALU_XOR    = 6'd5;
    localparam alu_op_t ALU_SRL    = 6'd6;
    localparam alu_op_t ALU_SRA    = 6'd7;
    localparam alu_op_t ALU_OR     = 6'd8;
    localparam alu_op_t ALU_AND    = 6'd9;
    localparam alu_op_t ALU_ADDW   = 6'd10;
    localparam alu_op_t ALU_SUBW   = 6'd11;
    localparam alu_op_t ALU_SLLW   = 6'd12;
    localparam alu_op_t ALU_SRLW   = 6'd13;
    localparam alu_op_t ALU_SRAW   = 6'd14;
    localparam alu_op_t ALU_MUL    = 6'd15;
    localparam alu_op_t ALU_MULH   = 6'd16;
    localparam alu_op_t ALU_MULHSU = 6'd17;
    localparam alu_op_t ALU_MULHU  = 6'd18;
    localparam alu_op_t ALU_DIV    = 6'd19;
    localparam alu_op_t ALU_DIVU   = 6'd20;
    localparam alu_op_t ALU_REM    = 6'd21;
    localparam alu_op_t ALU_REMU   = 6'd22;
    localparam alu_op_t ALU_MULW   = 6'd23;
    localparam alu_op_t ALU_DIVW   = 6'd24;
    localparam alu_op_t ALU_DIVUW  = 6'd25;
    localparam alu_op_t ALU_REMW   = 6'd26;
    localparam alu_op_t ALU_REMUW  = 6'd27;
    localparam alu_op_t ALU_BEQ    = 6'd28;
    localparam alu_op_t ALU_BNE    = 6'd29;
    localparam alu_op_t ALU_BGE    = 6'd30;
    localparam alu_op_t ALU_BGEU   = 6'd31;
    localparam alu_op_t ALU_PASS2  = 6'd32;

    typedef struct packed {
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic [ALUOP_W-1:0] alu_op;
        logic [XLEN-1:0]    pc;
        logic [4:0]         rd_idx;
        logic               rd_wen;
    } ex_payload_t;

    // Bit 1 = main entry occupied, bit 0 = skid entry occupied.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_SKID_ONLY = 2'b01,
        ST_ONE       = 2'b10,
        ST_FULL      = 2'b11
    } occ_state_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the ID->EX handshake, the MEM/WB bypass taps, the flush line and the
// EX->ALU handshake.
//   slave  : the id_ex_stage itself (consumes in_*, bypass, flush, out_ready;
//            produces in_ready and out_*)
//   master : the environment around the stage (ID, MEM, WB, ALU)
// -----------------------------------------------------------------------------
interface id_ex_stage_if;
    import npc_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [XLEN-1:0]    in_pc;
    logic [4:0]         in_rs1_idx;
    logic [4:0]         in_rs2_idx;
    logic [XLEN-1:0]    in_rs1_data;
    logic [XLEN-1:0]    in_rs2_data;
    logic [XLEN-1:0]    in_imm;
    logic               in_op1_pc;
    logic               in_op2_imm;
    logic [ALUOP_W-1:0] in_alu_op;
    logic [4:0]         in_rd_idx;
    logic               in_rd_wen;

    logic               mem_fwd_wen;
    logic [4:0]         mem_fwd_rd;
    logic [XLEN-1:0]    mem_fwd_data;
    logic               mem_fwd_is_load;
    logic               wb_fwd_wen;
    logic [4:0]         wb_fwd_rd;
    logic [XLEN-1:0]    wb_fwd_data;

    logic               flush;

    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_operator_1;
    logic [XLEN-1:0]    out_operator_2;
    logic [ALUOP_W-1:0] out_alu_op;
    logic [XLEN-1:0]    out_pc;
    logic [4:0]         out_rd_idx;
    logic               out_rd_wen;

    modport slave (
        input  in_valid, in_pc, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_op1_pc, in_op2_imm, in_alu_op, in_rd_idx, in_rd_wen,
               mem_fwd_wen, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
               wb_fwd_wen, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        output in_ready, out_valid, out_operator_1, out_operator_2, out_alu_op,
               out_pc, out_rd_idx, out_rd_wen
    );

    modport master (
        output in_valid, in_pc, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_op1_pc, in_op2_imm, in_alu_op, in_rd_idx, in_rd_wen,
               mem_fwd_wen, mem_fwd_rd, mem_fwd_data, mem_fwd_is_load,
               wb_fwd_wen, wb_fwd_rd, wb_fwd_data, flush, out_ready,
        input  in_ready, out_valid, out_operator_1, out_operator_2, out_alu_op,
               out_pc, out_rd_idx, out_rd_wen
    );

endinterface

// File: rtl/id_ex_stage_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Bypass selection for one source register.
//   srcIdx/rfData          : source index and register-file read data
//   srcUsed                : the instruction really reads this source
//   mem*/wb*               : MEM and WB write-back taps
//   fwdData                : x0 -> 0, else MEM hit, else WB hit, else RF data
//   loadHit                : a used source depends on a load still in MEM
// -----------------------------------------------------------------------------
module fwd_sel
    import npc_pkg::*;
(
    input  logic [4:0]      srcIdx,
    input  logic [XLEN-1:0] rfData,
    input  logic            srcUsed,
    input  logic            memWen,
    input  logic [4:0]      memRd,
    input  logic [XLEN-1:0] memData,
    input  logic            memIsLoad,
    input  logic            wbWen,
    input  logic [4:0]      wbRd,
    input  logic [XLEN-1:0] wbData,
    output logic [XLEN-1:0] fwdData,
    output logic            loadHit
);

    logic notZero;
    logic memHit;
    logic wbHit;

    assign notZero = (srcIdx != 5'd0);
    assign memHit  = memWen && (memRd == srcIdx) && notZero;
    assign wbHit   = wbWen  && (wbRd  == srcIdx) && notZero;

    // The younger producer (MEM) shadows the older one (WB).
    always_comb begin
        fwdData = rfData;
        if (!notZero) begin
            fwdData = '0;
        end else if (memHit) begin
            fwdData = memData;
        end else if (wbHit) begin
            fwdData = wbData;
        end
    end

    // Load data is not available until the load leaves MEM, so we must wait.
    assign loadHit = srcUsed && memIsLoad && (memRd == srcIdx) && notZero;

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// Execute-stage front end: bypasses both sources, stalls on load-use, picks the
// two ALU operands and registers them (plus sideband) in a main entry that
// drives the ALU. A one-entry skid buffer keeps in_ready free of any
// combinational dependence on out_ready.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : id_ex_stage_if.slave (ID handshake, bypass taps, flush,
//                ALU-side handshake and operands)
// -----------------------------------------------------------------------------
module id_ex_stage
    import npc_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    id_ex_stage_if.slave bus
);

    occ_state_t      state;
    occ_state_t      stateNext;
    ex_payload_t     mainQ;
    ex_payload_t     skidQ;
    ex_payload_t     inPayload;

    logic            mainValid;
    logic            skidValid;
    logic            hazard;
    logic            accept;
    logic            fire;
    logic            loadMainIn;
    logic            loadMainSkid;
    logic            loadSkidIn;

    logic            rs1Used;
    logic            rs2Used;
    logic            rs1LoadHit;
    logic            rs2LoadHit;
    logic [XLEN-1:0] rs1Fwd;
    logic [XLEN-1:0] rs2Fwd;

    assign rs1Used = !bus.in_op1_pc;
    assign rs2Used = !bus.in_op2_imm;

    fwd_sel rs1Sel (
        .srcIdx    (bus.in_rs1_idx),
        .rfData    (bus.in_rs1_data),
        .srcUsed   (rs1Used),
        .memWen    (bus.mem_fwd_wen),
        .memRd     (bus.mem_fwd_rd),
        .memData   (bus.mem_fwd_data),
        .memIsLoad (bus.mem_fwd_is_load),
        .wbWen     (bus.wb_fwd_wen),
        .wbRd      (bus.wb_fwd_rd),
        .wbData    (bus.wb_fwd_data),
        .fwdData   (rs1Fwd),
        .loadHit   (rs1LoadHit)
    );

    fwd_sel rs2Sel (
        .srcIdx    (bus.in_rs2_idx),
        .rfData    (bus.in_rs2_data),
        .srcUsed   (rs2Used),
        .memWen    (bus.mem_fwd_wen),
        .memRd     (bus.mem_fwd_rd),
        .memData   (bus.mem_fwd_data),
        .memIsLoad (bus.mem_fwd_is_load),
        .wbWen     (bus.wb_fwd_wen),
        .wbRd      (bus.wb_fwd_rd),
        .wbData    (bus.wb_fwd_data),
        .fwdData   (rs2Fwd),
        .loadHit   (rs2LoadHit)
    );

    // Operands are resolved at accept time; later MEM/WB changes do not
    // affect an instruction already held in main or skid.
    always_comb begin
        inPayload        = '0;
        inPayload.op1    = bus.in_op1_pc  ? bus.in_pc  : rs1Fwd;
        inPayload.op2    = bus.in_op2_imm ? bus.in_imm : rs2Fwd;
        inPayload.alu_op = bus.in_alu_op;
        inPayload.pc     = bus.in_pc;
        inPayload.rd_idx = bus.in_rd_idx;
        inPayload.rd_wen = bus.in_rd_wen;
    end

    assign mainValid = state[1];
    assign skidValid = state[0];
    assign hazard    = rs1LoadHit || rs2LoadHit;

    // in_ready looks only at the skid slot, so out_ready never reaches it.
    assign bus.in_ready = !skidValid && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign fire         = mainValid && bus.out_ready;

    // Occupancy control. Flush wins over everything; a fire during flush
    // still completes downstream because the ALU sampled it this cycle.
    always_comb begin
        stateNext    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkidIn   = 1'b0;
        if (bus.flush) begin
            stateNext = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        stateNext  = ST_ONE;
                        loadMainIn = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (fire && accept) begin
                        loadMainIn = 1'b1;
                    end else if (fire) begin
                        stateNext = ST_EMPTY;
                    end else if (accept) begin
                        stateNext  = ST_FULL;
                        loadSkidIn = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (fire) begin
                        stateNext    = ST_ONE;
                        loadMainSkid = 1'b1;
                    end
                end
                default: begin
                    stateNext = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload registers; reset clears every entry immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
            mainQ <= '0;
            skidQ <= '0;
        end else begin
            state <= stateNext;
            if (loadMainIn) begin
                mainQ <= inPayload;
            end else if (loadMainSkid) begin
                mainQ <= skidQ;
            end
            if (loadSkidIn) begin
                skidQ <= inPayload;
            end
        end
    end

    // Skid is only ever filled behind a stalled main entry.
    assert property (@(posedge clk) disable iff (!rst_n) state != ST_SKID_ONLY);

    assign bus.out_valid      = mainValid;
    assign bus.out_operator_1 = mainQ.op1;
    assign bus.out_operator_2 = mainQ.op2;
    assign bus.out_alu_op     = mainQ.alu_op;
    assign bus.out_pc         = mainQ.pc;
    assign bus.out_rd_idx     = mainQ.rd_idx;
    assign bus.out_rd_wen     = mainQ.rd_wen;

endmodule
